// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and flag helper for adder wrapper stages
package adder_pkg;

  localparam int ADDER_WIDTH = 64;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  // Returns {carry, ovf} from the operand and sum sign bits alone.
  function automatic logic [1:0] add_flags(input logic a_msb,
                                           input logic b_msb,
                                           input logic s_msb);
    logic carry;
    logic ovf;
    carry = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
    ovf   = (a_msb == b_msb) & (s_msb != a_msb);
    return {carry, ovf};
  endfunction

endpackage

// File: rtl/adder_flag_calc.sv
// rtl/adder_flag_calc.sv - combinational carry/overflow from operand and sum MSBs
module adder_flag_calc
  import adder_pkg::*;
(
  input  logic a_msb,
  input  logic b_msb,
  input  logic s_msb,
  output logic carry,
  output logic ovf
);

  assign {carry, ovf} = add_flags(a_msb, b_msb, s_msb);

endmodule

// File: rtl/adder_operand_sequencer.sv
// rtl/adder_operand_sequencer.sv - handshaked operand/result stage around an external combinational adder
module adder_operand_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH         = ADDER_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     IN_A,
  input  logic [WIDTH-1:0]     IN_B,
  output logic [WIDTH-1:0]     ADD_A,
  output logic [WIDTH-1:0]     ADD_B,
  input  logic [WIDTH-1:0]     ADD_SUM,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     OUT_SUM,
  output logic                 OUT_CARRY,
  output logic                 OUT_OVF,
  output logic [CNT_WIDTH-1:0] DONE_COUNT
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     add_a_q, add_a_d;
  logic [WIDTH-1:0]     add_b_q, add_b_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_sum_q, out_sum_d;
  logic                 out_carry_q, out_carry_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [CNT_WIDTH-1:0] done_q, done_d;
  logic                 in_ready_c;
  logic                 flag_carry;
  logic                 flag_ovf;

  adder_flag_calc u_flag_calc (
    .a_msb (add_a_q[WIDTH-1]),
    .b_msb (add_b_q[WIDTH-1]),
    .s_msb (ADD_SUM[WIDTH-1]),
    .carry (flag_carry),
    .ovf   (flag_ovf)
  );

  // HOLD forwards OUT_READY so a consumed result can overlap the next accept.
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_c = 1'b1;
      S_HOLD:  in_ready_c = OUT_READY;
      default: in_ready_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          add_a_d = IN_A;
          add_b_d = IN_B;
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          out_sum_d   = ADD_SUM;
          out_carry_d = flag_carry;
          out_ovf_d   = flag_ovf;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (OUT_READY) begin
          done_d      = done_q + CNT_WIDTH'(1);
          out_valid_d = 1'b0;
          if (IN_VALID) begin
            add_a_d = IN_A;
            add_b_d = IN_B;
            cnt_d   = SETTLE_LOAD;
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      done_q      <= done_d;
    end
  end

  assign IN_READY   = in_ready_c;
  assign ADD_A      = add_a_q;
  assign ADD_B      = add_b_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_SUM    = out_sum_q;
  assign OUT_CARRY  = out_carry_q;
  assign OUT_OVF    = out_ovf_q;
  assign DONE_COUNT = done_q;

endmodule
